// File: rtl/pipelined_control_unit_if.sv
// ============================================================================
// Module      : pipelined_control_unit_if
// Description : Decode inputs, pipeline control outputs and hazard/forwarding
//               signals of pipelined_control_unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipelined_control_unit_if #(
    parameter int OPCODE_W   = 3,
    parameter int DIR_W      = 2,
    parameter int TYPE_W     = 2,
    parameter int ALU_CTRL_W = 3,
    parameter int RD_W       = 4
);
    logic                  id_valid;
    logic [OPCODE_W-1:0]   id_opcode;
    logic [DIR_W-1:0]      id_dir_mode;
    logic [TYPE_W-1:0]     id_inst_type;
    logic [RD_W-1:0]       id_rd;
    logic [RD_W-1:0]       id_rs1;
    logic [RD_W-1:0]       id_rs2;
    logic                  hold;
    logic                  flush;
    logic                  hazard_stall;
    logic                  id_illegal;
    logic                  ex_valid;
    logic                  ex_alu_source;
    logic                  ex_jump;
    logic                  ex_branch;
    logic                  ex_is_rd;
    logic                  ex_imm_src;
    logic [ALU_CTRL_W-1:0] ex_alu_control;
    logic [OPCODE_W-1:0]   ex_branch_cond;
    logic                  mem_valid;
    logic                  mem_mem_write;
    logic                  mem_reg_write;
    logic [1:0]            mem_result_source;
    logic [RD_W-1:0]       mem_rd;
    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [1:0]            wb_result_source;
    logic [RD_W-1:0]       wb_rd;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;

    modport master (
        output id_valid, id_opcode, id_dir_mode, id_inst_type, id_rd, id_rs1, id_rs2,
               hold, flush,
        input  hazard_stall, id_illegal,
               ex_valid, ex_alu_source, ex_jump, ex_branch, ex_is_rd, ex_imm_src,
               ex_alu_control, ex_branch_cond,
               mem_valid, mem_mem_write, mem_reg_write, mem_result_source, mem_rd,
               wb_valid, wb_reg_write, wb_result_source, wb_rd, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_opcode, id_dir_mode, id_inst_type, id_rd, id_rs1, id_rs2,
               hold, flush,
        output hazard_stall, id_illegal,
               ex_valid, ex_alu_source, ex_jump, ex_branch, ex_is_rd, ex_imm_src,
               ex_alu_control, ex_branch_cond,
               mem_valid, mem_mem_write, mem_reg_write, mem_result_source, mem_rd,
               wb_valid, wb_reg_write, wb_result_source, wb_rd, fwd_a, fwd_b
    );
endinterface

`default_nettype wire

// File: rtl/pipelined_control_unit.sv
// ============================================================================
// Module      : pipelined_control_unit
// Description : ID decode plus ID/EX, EX/MEM, MEM/WB control registers with
//               hold/flush/bubble and RAW hazard detection. Optional macro
//               CTRL_FWD_EN enables EX operand forwarding (load-use stall only).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_control_unit #(
    parameter int OPCODE_W   = 3,
    parameter int DIR_W      = 2,
    parameter int TYPE_W     = 2,
    parameter int ALU_CTRL_W = 3,
    parameter int RD_W       = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    pipelined_control_unit_if.slave  bus
);
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_LINK = 2'b10;

    typedef struct packed {
        logic                  alu_source;
        logic                  reg_write;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic                  is_rd;
        logic                  imm_src;
        logic [1:0]            result_source;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic [OPCODE_W-1:0]   branch_cond;
    } ctrl_t;

    ctrl_t             dec;
    logic              legal, no_rs1, use_rs1, use_rs2, stall;
    logic              ex_hit, mem_hit, wb_hit;

    logic              ex_valid_q, ex_valid_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic [RD_W-1:0]   ex_rd_q, ex_rd_d;
    logic              mem_valid_q, mem_valid_d, mem_reg_write_q, mem_reg_write_d;
    logic              mem_mem_write_q, mem_mem_write_d;
    logic [1:0]        mem_result_source_q, mem_result_source_d;
    logic [RD_W-1:0]   mem_rd_q, mem_rd_d;
    logic              wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
    logic [1:0]        wb_result_source_q, wb_result_source_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
`ifdef CTRL_FWD_EN
    logic [RD_W-1:0]   ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
`endif

    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        no_rs1 = 1'b0;
        if (bus.id_dir_mode == DIR_W'(0) && bus.id_inst_type == TYPE_W'(0)) begin
            if (bus.id_opcode <= OPCODE_W'(4)) begin
                legal = 1'b1; dec.reg_write = 1'b1; dec.is_rd = 1'b1;
                dec.alu_control = ALU_CTRL_W'(bus.id_opcode);
            end
        end else if (bus.id_dir_mode == DIR_W'(1) && bus.id_inst_type == TYPE_W'(0)) begin
            if (bus.id_opcode == OPCODE_W'(0) || bus.id_opcode == OPCODE_W'(5) ||
                bus.id_opcode == OPCODE_W'(6)) begin
                legal = 1'b1; dec.alu_source = 1'b1; dec.reg_write = 1'b1; dec.is_rd = 1'b1;
                dec.alu_control = ALU_CTRL_W'(bus.id_opcode);
            end
        end else if (bus.id_dir_mode == DIR_W'(1) && bus.id_inst_type == TYPE_W'(1)) begin
            if (bus.id_opcode == OPCODE_W'(0)) begin
                legal = 1'b1; dec.alu_source = 1'b1; dec.mem_write = 1'b1;
            end else if (bus.id_opcode <= OPCODE_W'(3)) begin
                legal = 1'b1; dec.result_source = RES_LOAD; dec.alu_source = 1'b1;
                dec.reg_write = 1'b1; dec.is_rd = 1'b1;
            end
        end else if (bus.id_dir_mode == DIR_W'(1) && bus.id_inst_type == TYPE_W'(2)) begin
            if (bus.id_opcode == OPCODE_W'(0)) begin
                legal = 1'b1; dec.result_source = RES_LINK; dec.alu_source = 1'b1;
                dec.reg_write = 1'b1; dec.jump = 1'b1; dec.is_rd = 1'b1;
            end else if (bus.id_opcode <= OPCODE_W'(4)) begin
                legal = 1'b1; dec.branch = 1'b1; dec.branch_cond = bus.id_opcode;
            end
        end else if (bus.id_dir_mode == DIR_W'(2) && bus.id_inst_type == TYPE_W'(2)) begin
            if (bus.id_opcode == OPCODE_W'(1)) begin
                legal = 1'b1; no_rs1 = 1'b1; dec.result_source = RES_LINK;
                dec.alu_source = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1; dec.is_rd = 1'b1;
            end
        end else if (bus.id_dir_mode == DIR_W'(2) && bus.id_inst_type == TYPE_W'(0)) begin
            if (bus.id_opcode == OPCODE_W'(0)) begin
                legal = 1'b1; no_rs1 = 1'b1; dec.alu_source = 1'b1; dec.reg_write = 1'b1;
                dec.is_rd = 1'b1; dec.imm_src = 1'b1; dec.alu_control = ALU_CTRL_W'(5);
            end
        end
    end

    assign use_rs1 = legal & ~no_rs1;
    assign use_rs2 = legal & (~dec.alu_source | dec.mem_write | dec.branch);

    // Writer hits against the ID sources; register 0 never creates a dependency.
    assign ex_hit  = ex_valid_q & ex_ctrl_q.reg_write & (ex_rd_q != '0) &
                     ((use_rs1 & (ex_rd_q == bus.id_rs1)) | (use_rs2 & (ex_rd_q == bus.id_rs2)));
    assign mem_hit = mem_reg_write_q & (mem_rd_q != '0) &
                     ((use_rs1 & (mem_rd_q == bus.id_rs1)) | (use_rs2 & (mem_rd_q == bus.id_rs2)));
    assign wb_hit  = wb_reg_write_q & (wb_rd_q != '0) &
                     ((use_rs1 & (wb_rd_q == bus.id_rs1)) | (use_rs2 & (wb_rd_q == bus.id_rs2)));

`ifdef CTRL_FWD_EN
    assign stall = bus.id_valid & (ex_hit & (ex_ctrl_q.result_source == RES_LOAD));

    always_comb begin
        bus.fwd_a = 2'b00;
        bus.fwd_b = 2'b00;
        if (mem_reg_write_q && mem_rd_q != '0 && mem_rd_q == ex_rs1_q)     bus.fwd_a = 2'b01;
        else if (wb_reg_write_q && wb_rd_q != '0 && wb_rd_q == ex_rs1_q)   bus.fwd_a = 2'b10;
        if (mem_reg_write_q && mem_rd_q != '0 && mem_rd_q == ex_rs2_q)     bus.fwd_b = 2'b01;
        else if (wb_reg_write_q && wb_rd_q != '0 && wb_rd_q == ex_rs2_q)   bus.fwd_b = 2'b10;
    end
`else
    assign stall     = bus.id_valid & (ex_hit | mem_hit | wb_hit);
    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
`endif

    always_comb begin
        ex_valid_d          = ex_valid_q;
        ex_ctrl_d           = ex_ctrl_q;
        ex_rd_d             = ex_rd_q;
        mem_valid_d         = mem_valid_q;
        mem_reg_write_d     = mem_reg_write_q;
        mem_mem_write_d     = mem_mem_write_q;
        mem_result_source_d = mem_result_source_q;
        mem_rd_d            = mem_rd_q;
        wb_valid_d          = wb_valid_q;
        wb_reg_write_d      = wb_reg_write_q;
        wb_result_source_d  = wb_result_source_q;
        wb_rd_d             = wb_rd_q;
`ifdef CTRL_FWD_EN
        ex_rs1_d            = ex_rs1_q;
        ex_rs2_d            = ex_rs2_q;
`endif
        if (!bus.hold) begin
            // Unused sources are stored as 0 so they can never select a forward path.
            if (bus.flush || stall || !bus.id_valid || !legal) begin
                ex_valid_d = 1'b0; ex_ctrl_d = '0; ex_rd_d = '0;
`ifdef CTRL_FWD_EN
                ex_rs1_d = '0; ex_rs2_d = '0;
`endif
            end else begin
                ex_valid_d = 1'b1; ex_ctrl_d = dec; ex_rd_d = bus.id_rd;
`ifdef CTRL_FWD_EN
                ex_rs1_d = use_rs1 ? bus.id_rs1 : '0;
                ex_rs2_d = use_rs2 ? bus.id_rs2 : '0;
`endif
            end
            mem_valid_d         = ex_valid_q;
            mem_reg_write_d     = ex_valid_q & ex_ctrl_q.reg_write;
            mem_mem_write_d     = ex_valid_q & ex_ctrl_q.mem_write;
            mem_result_source_d = ex_ctrl_q.result_source;
            mem_rd_d            = ex_rd_q;
            wb_valid_d          = mem_valid_q;
            wb_reg_write_d      = mem_valid_q & mem_reg_write_q;
            wb_result_source_d  = mem_result_source_q;
            wb_rd_d             = mem_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0; ex_ctrl_q <= '0; ex_rd_q <= '0;
            mem_valid_q <= 1'b0; mem_reg_write_q <= 1'b0; mem_mem_write_q <= 1'b0;
            mem_result_source_q <= '0; mem_rd_q <= '0;
            wb_valid_q <= 1'b0; wb_reg_write_q <= 1'b0; wb_result_source_q <= '0; wb_rd_q <= '0;
`ifdef CTRL_FWD_EN
            ex_rs1_q <= '0; ex_rs2_q <= '0;
`endif
        end else begin
            ex_valid_q <= ex_valid_d; ex_ctrl_q <= ex_ctrl_d; ex_rd_q <= ex_rd_d;
            mem_valid_q <= mem_valid_d; mem_reg_write_q <= mem_reg_write_d;
            mem_mem_write_q <= mem_mem_write_d;
            mem_result_source_q <= mem_result_source_d; mem_rd_q <= mem_rd_d;
            wb_valid_q <= wb_valid_d; wb_reg_write_q <= wb_reg_write_d;
            wb_result_source_q <= wb_result_source_d; wb_rd_q <= wb_rd_d;
`ifdef CTRL_FWD_EN
            ex_rs1_q <= ex_rs1_d; ex_rs2_q <= ex_rs2_d;
`endif
        end
    end

    assign bus.hazard_stall      = stall;
    assign bus.id_illegal        = bus.id_valid & ~legal;
    assign bus.ex_valid          = ex_valid_q;
    assign bus.ex_alu_source     = ex_ctrl_q.alu_source;
    assign bus.ex_jump           = ex_ctrl_q.jump;
    assign bus.ex_branch         = ex_ctrl_q.branch;
    assign bus.ex_is_rd          = ex_ctrl_q.is_rd;
    assign bus.ex_imm_src        = ex_ctrl_q.imm_src;
    assign bus.ex_alu_control    = ex_ctrl_q.alu_control;
    assign bus.ex_branch_cond    = ex_ctrl_q.branch_cond;
    assign bus.mem_valid         = mem_valid_q;
    assign bus.mem_mem_write     = mem_mem_write_q;
    assign bus.mem_reg_write     = mem_reg_write_q;
    assign bus.mem_result_source = mem_result_source_q;
    assign bus.mem_rd            = mem_rd_q;
    assign bus.wb_valid          = wb_valid_q;
    assign bus.wb_reg_write      = wb_reg_write_q;
    assign bus.wb_result_source  = wb_result_source_q;
    assign bus.wb_rd             = wb_rd_q;
endmodule

`default_nettype wire
